hdmi_frame_sequencer: RTL and testbench

//  Drives the HDMI output port (hdmi_vs, hdmi_de, hdmi_data) from a valid/ready pixel stream.

---
 rtl/hdmi_frame_sequencer.sv | 191 +++++++++++++++++++
 tb/tb_hdmi_frame_sequencer.sv | 299 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/hdmi_frame_sequencer.sv
// rtl/hdmi_frame_sequencer.sv - Raster timing generator that paces a valid/ready pixel stream onto the HDMI port
// Optional test-pattern source enabled by defining HDMI_FRAME_SEQ_PATTERN_EN (adds pattern_sel input).
module hdmi_frame_sequencer #(
    parameter int H_ACTIVE        = 800,
    parameter int H_FP            = 40,
    parameter int H_SYNC          = 128,
    parameter int H_BP            = 88,
    parameter int V_ACTIVE        = 300,
    parameter int V_FP            = 1,
    parameter int V_SYNC          = 4,
    parameter int V_BP            = 23,
    parameter int SYNC_ACTIVE_LOW = 1
) (
    input  logic        hdmi_clk,
    input  logic        rst,
    input  logic        enable,
    input  logic        pix_valid,
    input  logic        pix_sof,
    input  logic [23:0] pix_data,
`ifdef HDMI_FRAME_SEQ_PATTERN_EN
    input  logic        pattern_sel,
`endif
    output logic        pix_ready,
    output logic        hdmi_hs,
    output logic        hdmi_vs,
    output logic        hdmi_de,
    output logic [31:0] hdmi_data,
    output logic        underflow,
    output logic [7:0]  frame_cnt
);

    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
    localparam int HW      = $clog2(H_TOTAL);
    localparam int VW      = $clog2(V_TOTAL);

    localparam logic [HW-1:0] H_LAST   = HW'(H_TOTAL - 1);
    localparam logic [HW-1:0] H_ACT    = HW'(H_ACTIVE);
    localparam logic [HW-1:0] HS_FIRST = HW'(H_ACTIVE + H_FP);
    localparam logic [HW-1:0] HS_LAST  = HW'(H_ACTIVE + H_FP + H_SYNC - 1);
    localparam logic [VW-1:0] V_LAST   = VW'(V_TOTAL - 1);
    localparam logic [VW-1:0] V_ACT    = VW'(V_ACTIVE);
    localparam logic [VW-1:0] VS_FIRST = VW'(V_ACTIVE + V_FP);
    localparam logic [VW-1:0] VS_LAST  = VW'(V_ACTIVE + V_FP + V_SYNC - 1);
    localparam logic          SYNC_OFF = (SYNC_ACTIVE_LOW != 0);

    typedef enum logic [1:0] {
        S_IDLE,
        S_ALIGN,
        S_RUN,
        S_RESYNC
    } state_t;

    state_t        r_state;
    logic [HW-1:0] r_h_cnt;
    logic [VW-1:0] r_v_cnt;
    logic          r_hs;
    logic          r_vs;
    logic          r_de;
    logic [31:0]   r_data;
    logic          r_underflow;
    logic [7:0]    r_frame_cnt;

    logic          w_active;
    logic          w_first;
    logic          w_last;
    logic          w_hs_on;
    logic          w_vs_on;
    logic          w_pat;
    logic [31:0]   w_pattern;
    logic          w_ready;

    assign w_active = (r_h_cnt < H_ACT) && (r_v_cnt < V_ACT);
    assign w_first  = (r_h_cnt == '0) && (r_v_cnt == '0);
    assign w_last   = (r_h_cnt == H_LAST) && (r_v_cnt == V_LAST);
    assign w_hs_on  = (r_h_cnt >= HS_FIRST) && (r_h_cnt <= HS_LAST);
    assign w_vs_on  = (r_v_cnt >= VS_FIRST) && (r_v_cnt <= VS_LAST);

`ifdef HDMI_FRAME_SEQ_PATTERN_EN
    logic       r_pat;
    logic [7:0] w_h8;
    logic [7:0] w_v8;

    // The first pixel of a frame must already obey the selection sampled on that same cycle.
    assign w_pat     = w_first ? pattern_sel : r_pat;
    assign w_h8      = 8'(r_h_cnt);
    assign w_v8      = 8'(r_v_cnt);
    assign w_pattern = {8'h00, w_h8, w_v8, w_h8 ^ w_v8};

    always_ff @(posedge hdmi_clk or posedge rst) begin
        if (rst) begin
            r_pat <= 1'b0;
        end else if (r_state != S_IDLE && w_first) begin
            r_pat <= pattern_sel;
        end
    end
`else
    assign w_pat     = 1'b0;
    assign w_pattern = '0;
`endif

    // While aligning, a pending sof pixel is held back so it lands exactly on (0,0).
    always_comb begin
        w_ready = 1'b0;
        case (r_state)
            S_ALIGN:  w_ready = !w_pat && (w_first || (!w_active && !pix_sof));
            S_RUN:    w_ready = !w_pat && w_active;
            S_RESYNC: w_ready = !w_pat;
            default:  w_ready = 1'b0;
        endcase
    end

    always_ff @(posedge hdmi_clk or posedge rst) begin
        if (rst) begin
            r_state     <= S_IDLE;
            r_h_cnt     <= '0;
            r_v_cnt     <= '0;
            r_hs        <= SYNC_OFF;
            r_vs        <= SYNC_OFF;
            r_de        <= 1'b0;
            r_data      <= '0;
            r_underflow <= 1'b0;
            r_frame_cnt <= '0;
        end else begin
            r_hs   <= SYNC_OFF ^ ((r_state != S_IDLE) && w_hs_on);
            r_vs   <= SYNC_OFF ^ ((r_state != S_IDLE) && w_vs_on);
            r_de   <= (r_state != S_IDLE) && w_active;
            r_data <= '0;

            if (r_state == S_IDLE) begin
                r_h_cnt <= '0;
                r_v_cnt <= '0;
                if (enable) begin
                    r_state <= S_ALIGN;
                end
            end else begin
                if (r_h_cnt == H_LAST) begin
                    r_h_cnt <= '0;
                    r_v_cnt <= (r_v_cnt == V_LAST) ? '0 : r_v_cnt + 1'b1;
                end else begin
                    r_h_cnt <= r_h_cnt + 1'b1;
                end

                case (r_state)
                    S_ALIGN: begin
                        if (w_first && (w_pat || (pix_valid && pix_sof))) begin
                            r_state     <= S_RUN;
                            r_frame_cnt <= r_frame_cnt + 8'd1;
                            r_data      <= w_pat ? w_pattern : {8'h00, pix_data};
                        end
                    end
                    S_RUN: begin
                        if (w_first) begin
                            r_frame_cnt <= r_frame_cnt + 8'd1;
                        end
                        if (w_active) begin
                            if (w_pat) begin
                                r_data <= w_pattern;
                            end else if (pix_valid) begin
                                r_data <= {8'h00, pix_data};
                            end else begin
                                r_underflow <= 1'b1;
                                r_state     <= S_RESYNC;
                            end
                        end
                    end
                    S_RESYNC: begin
                        if (w_last) begin
                            r_state <= S_ALIGN;
                        end
                    end
                    default: r_state <= S_IDLE;
                endcase

                // Run requests only take effect on a frame boundary.
                if (w_last && !enable) begin
                    r_state <= S_IDLE;
                end
            end
        end
    end

    assign pix_ready = w_ready;
    assign hdmi_hs   = r_hs;
    assign hdmi_vs   = r_vs;
    assign hdmi_de   = r_de;
    assign hdmi_data = r_data;
    assign underflow = r_underflow;
    assign frame_cnt = r_frame_cnt;

endmodule

// File: tb/tb_hdmi_frame_sequencer.sv
// tb/tb_hdmi_frame_sequencer.sv - Scoreboard bench for hdmi_frame_sequencer on a 7x5 raster
module tb_hdmi_frame_sequencer;

    logic        clk       = 1'b0;
    logic        rst       = 1'b1;
    logic        enable    = 1'b0;
    logic        pix_valid = 1'b0;
    logic        pix_sof   = 1'b0;
    logic [23:0] pix_data  = '0;
`ifdef HDMI_FRAME_SEQ_PATTERN_EN
    logic        pattern_sel = 1'b0;
`endif
    wire         pix_ready;
    wire         hdmi_hs;
    wire         hdmi_vs;
    wire         hdmi_de;
    wire  [31:0] hdmi_data;
    wire         underflow;
    wire  [7:0]  frame_cnt;

    int total = 0;
    int bad   = 0;

    logic [25:0] src_q[$];
    logic [31:0] exp_q[$];
    bit          acc = 1'b0;

    always #5 clk = ~clk;

    hdmi_frame_sequencer #(
        .H_ACTIVE(4), .H_FP(1), .H_SYNC(1), .H_BP(1),
        .V_ACTIVE(2), .V_FP(1), .V_SYNC(1), .V_BP(1),
        .SYNC_ACTIVE_LOW(1)
    ) dut (
        .hdmi_clk (clk),
        .rst      (rst),
        .enable   (enable),
        .pix_valid(pix_valid),
        .pix_sof  (pix_sof),
        .pix_data (pix_data),
`ifdef HDMI_FRAME_SEQ_PATTERN_EN
        .pattern_sel(pattern_sel),
`endif
        .pix_ready(pix_ready),
        .hdmi_hs  (hdmi_hs),
        .hdmi_vs  (hdmi_vs),
        .hdmi_de  (hdmi_de),
        .hdmi_data(hdmi_data),
        .underflow(underflow),
        .frame_cnt(frame_cnt)
    );

    // Stream source: entries are {valid, sof, data}; an entry leaves when the DUT was ready.
    always @(negedge clk) begin
        if (acc && src_q.size() > 0) void'(src_q.pop_front());
        if (src_q.size() > 0) {pix_valid, pix_sof, pix_data} = src_q[0];
        else {pix_valid, pix_sof, pix_data} = '0;
        #1;
        acc = pix_ready && (src_q.size() > 0);
    end

    task automatic do_reset();
        @(negedge clk);
        #2;
        rst    = 1'b1;
        enable = 1'b0;
        src_q.delete();
        exp_q.delete();
        repeat (2) @(negedge clk);
        #2 rst = 1'b0;
    endtask

    task automatic push_frame(input logic [23:0] base);
        for (int i = 0; i < 8; i++) begin
            src_q.push_back({1'b1, 1'(i == 0), base + 24'(i)});
        end
    endtask

    task automatic push_exp_frame(input logic [23:0] base);
        for (int i = 0; i < 8; i++) begin
            exp_q.push_back({8'h00, base + 24'(i)});
        end
    endtask

    task automatic test_reset();
        repeat (2) @(negedge clk);
        #2;
        total++; if (hdmi_de !== 1'b0) begin bad++; $display("FAIL reset_de got=%b want=0", hdmi_de); end
        total++; if (hdmi_data !== 32'h0) begin bad++; $display("FAIL reset_data got=%h want=0", hdmi_data); end
        total++; if (hdmi_hs !== 1'b1) begin bad++; $display("FAIL reset_hs got=%b want=1", hdmi_hs); end
        total++; if (hdmi_vs !== 1'b1) begin bad++; $display("FAIL reset_vs got=%b want=1", hdmi_vs); end
        total++; if (pix_ready !== 1'b0) begin bad++; $display("FAIL reset_ready got=%b want=0", pix_ready); end
        total++; if (underflow !== 1'b0) begin bad++; $display("FAIL reset_underflow got=%b want=0", underflow); end
        total++; if (frame_cnt !== 8'd0) begin bad++; $display("FAIL reset_frame_cnt got=%0d want=0", frame_cnt); end
        rst = 1'b0;
        repeat (10) @(negedge clk);
        #2;
        total++; if (hdmi_de !== 1'b0) begin bad++; $display("FAIL idle_de got=%b want=0", hdmi_de); end
    endtask

    task automatic test_stream();
        int n_de = 0;
        int n_vs = 0;
        int n_hs = 0;
        logic [31:0] e;
        do_reset();
        push_frame(24'h102000);
        push_exp_frame(24'h102000);
        enable = 1'b1;
        for (int i = 1; i <= 36; i++) begin
            @(negedge clk);
            #2;
            if (hdmi_de) begin
                n_de++;
                total++;
                if (exp_q.size() == 0) begin
                    bad++; $display("FAIL stream_extra_de got=%h want=none", hdmi_data);
                end else begin
                    e = exp_q.pop_front();
                    if (hdmi_data !== e) begin bad++; $display("FAIL stream_data got=%h want=%h", hdmi_data, e); end
                end
            end
            if (!hdmi_vs) n_vs++;
            if (!hdmi_hs) n_hs++;
        end
        total++; if (n_de != 8) begin bad++; $display("FAIL stream_de_count got=%0d want=8", n_de); end
        total++; if (n_vs != 7) begin bad++; $display("FAIL stream_vs_low got=%0d want=7", n_vs); end
        total++; if (n_hs != 5) begin bad++; $display("FAIL stream_hs_low got=%0d want=5", n_hs); end
        total++; if (frame_cnt !== 8'd1) begin bad++; $display("FAIL stream_frame_cnt got=%0d want=1", frame_cnt); end
        total++; if (underflow !== 1'b0) begin bad++; $display("FAIL stream_underflow got=%b want=0", underflow); end
        total++; if (exp_q.size() != 0) begin bad++; $display("FAIL stream_missing got=%0d want=0", exp_q.size()); end
    endtask

    task automatic test_async_reset();
        do_reset();
        push_frame(24'h330000);
        enable = 1'b1;
        repeat (3) @(negedge clk);
        #2;
        total++; if (hdmi_de !== 1'b1) begin bad++; $display("FAIL arst_pre_de got=%b want=1", hdmi_de); end
        total++; if (frame_cnt !== 8'd1) begin bad++; $display("FAIL arst_pre_frame_cnt got=%0d want=1", frame_cnt); end
        rst = 1'b1;
        #1;
        total++; if (hdmi_de !== 1'b0) begin bad++; $display("FAIL arst_de got=%b want=0", hdmi_de); end
        total++; if (hdmi_data !== 32'h0) begin bad++; $display("FAIL arst_data got=%h want=0", hdmi_data); end
        total++; if (hdmi_hs !== 1'b1) begin bad++; $display("FAIL arst_hs got=%b want=1", hdmi_hs); end
        total++; if (hdmi_vs !== 1'b1) begin bad++; $display("FAIL arst_vs got=%b want=1", hdmi_vs); end
        total++; if (pix_ready !== 1'b0) begin bad++; $display("FAIL arst_ready got=%b want=0", pix_ready); end
        total++; if (frame_cnt !== 8'd0) begin bad++; $display("FAIL arst_frame_cnt got=%0d want=0", frame_cnt); end
    endtask

    task automatic test_underflow();
        logic [31:0] e;
        do_reset();
        for (int i = 0; i < 6; i++) begin
            src_q.push_back({1'b1, 1'(i == 0), 24'h5A0000 + 24'(i)});
            exp_q.push_back({8'h00, 24'h5A0000 + 24'(i)});
        end
        src_q.push_back(26'h0);
        exp_q.push_back(32'h0);
        exp_q.push_back(32'h0);
        enable = 1'b1;
        for (int i = 1; i <= 50; i++) begin
            @(negedge clk);
            #2;
            if (hdmi_de) begin
                total++;
                if (exp_q.size() == 0) begin
                    bad++; $display("FAIL underflow_extra_de got=%h want=none", hdmi_data);
                end else begin
                    e = exp_q.pop_front();
                    if (hdmi_data !== e) begin bad++; $display("FAIL underflow_data got=%h want=%h", hdmi_data, e); end
                end
            end
            if (i == 10) begin
                total++; if (underflow !== 1'b0) begin bad++; $display("FAIL underflow_early got=%b want=0", underflow); end
            end
            if (i == 11) begin
                total++; if (underflow !== 1'b1) begin bad++; $display("FAIL underflow_set got=%b want=1", underflow); end
            end
            if (i == 35) begin
                push_frame(24'h6B0000);
                push_exp_frame(24'h6B0000);
            end
        end
        total++; if (underflow !== 1'b1) begin bad++; $display("FAIL underflow_sticky got=%b want=1", underflow); end
        total++; if (frame_cnt !== 8'd2) begin bad++; $display("FAIL underflow_frame_cnt got=%0d want=2", frame_cnt); end
        total++; if (exp_q.size() != 0) begin bad++; $display("FAIL underflow_missing got=%0d want=0", exp_q.size()); end
    endtask

    task automatic test_align_holdoff();
        logic [31:0] e;
        do_reset();
        for (int i = 0; i < 3; i++) src_q.push_back({1'b1, 1'b0, 24'hEE0000 + 24'(i)});
        push_frame(24'h7C0000);
        for (int i = 0; i < 8; i++) exp_q.push_back(32'h0);
        push_exp_frame(24'h7C0000);
        enable = 1'b1;
        for (int i = 1; i <= 50; i++) begin
            @(negedge clk);
            #2;
            if (hdmi_de) begin
                total++;
                if (exp_q.size() == 0) begin
                    bad++; $display("FAIL align_extra_de got=%h want=none", hdmi_data);
                end else begin
                    e = exp_q.pop_front();
                    if (hdmi_data !== e) begin bad++; $display("FAIL align_data got=%h want=%h", hdmi_data, e); end
                end
            end
            if (i == 20) begin
                total++; if (pix_ready !== 1'b0) begin bad++; $display("FAIL align_sof_held got=%b want=0", pix_ready); end
            end
        end
        total++; if (frame_cnt !== 8'd1) begin bad++; $display("FAIL align_frame_cnt got=%0d want=1", frame_cnt); end
        total++; if (exp_q.size() != 0) begin bad++; $display("FAIL align_missing got=%0d want=0", exp_q.size()); end
    endtask

    task automatic test_enable_drop();
        int n_de = 0;
        logic [31:0] e;
        do_reset();
        push_frame(24'h910000);
        push_frame(24'h920000);
        push_exp_frame(24'h910000);
        enable = 1'b1;
        for (int i = 1; i <= 45; i++) begin
            @(negedge clk);
            #2;
            if (hdmi_de) begin
                n_de++;
                total++;
                if (exp_q.size() == 0) begin
                    bad++; $display("FAIL endrop_extra_de got=%h want=none", hdmi_data);
                end else begin
                    e = exp_q.pop_front();
                    if (hdmi_data !== e) begin bad++; $display("FAIL endrop_data got=%h want=%h", hdmi_data, e); end
                end
            end
            if (i == 10) enable = 1'b0;
        end
        total++; if (n_de != 8) begin bad++; $display("FAIL endrop_de_count got=%0d want=8", n_de); end
        total++; if (pix_ready !== 1'b0) begin bad++; $display("FAIL endrop_ready got=%b want=0", pix_ready); end
        total++; if (hdmi_de !== 1'b0) begin bad++; $display("FAIL endrop_de got=%b want=0", hdmi_de); end
        total++; if (frame_cnt !== 8'd1) begin bad++; $display("FAIL endrop_frame_cnt got=%0d want=1", frame_cnt); end
        total++; if (exp_q.size() != 0) begin bad++; $display("FAIL endrop_missing got=%0d want=0", exp_q.size()); end
    endtask

`ifdef HDMI_FRAME_SEQ_PATTERN_EN
    task automatic test_pattern();
        int n_de = 0;
        int n_ready = 0;
        logic [31:0] e;
        do_reset();
        pattern_sel = 1'b1;
        push_frame(24'hABCDE0);
        for (int v = 0; v < 2; v++)
            for (int h = 0; h < 4; h++)
                exp_q.push_back({8'h00, 8'(h), 8'(v), 8'(h ^ v)});
        enable = 1'b1;
        for (int i = 1; i <= 36; i++) begin
            @(negedge clk);
            #2;
            if (pix_ready) n_ready++;
            if (hdmi_de) begin
                total++;
                if (exp_q.size() == 0) begin
                    bad++; $display("FAIL pattern_extra_de got=%h want=none", hdmi_data);
                end else begin
                    e = exp_q.pop_front();
                    if (hdmi_data !== e) begin bad++; $display("FAIL pattern_data got=%h want=%h", hdmi_data, e); end
                end
                if (n_de == 6) begin
                    total++; if (hdmi_data !== 32'h00020103) begin bad++; $display("FAIL pattern_l1p2 got=%h want=00020103", hdmi_data); end
                end
                n_de++;
            end
        end
        total++; if (n_ready != 0) begin bad++; $display("FAIL pattern_ready got=%0d want=0", n_ready); end
        total++; if (underflow !== 1'b0) begin bad++; $display("FAIL pattern_underflow got=%b want=0", underflow); end
        total++; if (exp_q.size() != 0) begin bad++; $display("FAIL pattern_missing got=%0d want=0", exp_q.size()); end
    endtask
`endif

    initial begin
        test_reset();
        test_stream();
        test_async_reset();
        test_underflow();
        test_align_holdoff();
        test_enable_drop();
`ifdef HDMI_FRAME_SEQ_PATTERN_EN
        test_pattern();
`endif
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
